// File: rtl/stream_mux_rr_if.sv
// ---------------------------------------------------------------------------
// stream_mux_rr_if
// Bundles the control, N producer channels and the consumer channel of
// stream_mux_rr.
//   slave  modport : the multiplexer's view (drives in_ready/out_*)
//   master modport : the surrounding producers/consumer's view
// Signals:
//   mode      0 = explicit select, 1 = round-robin
//   sel       channel index used when mode = 0
//   in_valid  per-channel valid          in_ready  per-channel ready
//   in_data   packed channel data, ch k = in_data[k*W +: W]
//   out_valid / out_data / out_ready      output beat handshake
//   out_ch    channel index of the held beat (only with CH_ID_OUT_EN)
// Build option: define CH_ID_OUT_EN to add the out_ch signal.
// ---------------------------------------------------------------------------
interface stream_mux_rr_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic            mode;
  logic [SW-1:0]   sel;
  logic [N-1:0]    in_valid;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic            out_ready;
`ifdef CH_ID_OUT_EN
  logic [SW-1:0]   out_ch;

  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );
`else
  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
`endif
endinterface

// File: rtl/stream_mux_rr.sv
// ---------------------------------------------------------------------------
// stream_mux_rr
// N:1 streaming multiplexer with a registered output stage. The granted
// channel is either picked by sel (mode = 0) or by a round-robin arbiter
// that starts its search at a rotating pointer (mode = 1).
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  stream_mux_rr_if.slave (see interface header for signal list)
// Build option: define CH_ID_OUT_EN to register and drive bus.out_ch.
// ---------------------------------------------------------------------------
module stream_mux_rr #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  stream_mux_rr_if.slave   bus
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q,  out_data_d;
  logic [SW-1:0]   ptr_q,       ptr_d;
`ifdef CH_ID_OUT_EN
  logic [SW-1:0]   out_ch_q,    out_ch_d;
`endif

  logic            load;
  logic            granted;
  logic [SW-1:0]   grant_idx;
  logic [W-1:0]    grant_data;
  logic [SW:0]     rr_sum;
  logic [SW-1:0]   rr_idx;

  // The output register may take a new beat when empty or being drained.
  // Held low during reset so no in_ready bit is raised while rst is asserted.
  assign load = ~rst & (~out_valid_q | bus.out_ready);

  // NOTE: every variable assigned here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    granted    = 1'b0;
    grant_idx  = '0;
    grant_data = '0;
    rr_sum     = '0;
    rr_idx     = '0;

    if (!bus.mode) begin
      // sel values >= N match no channel and therefore never grant.
      for (int k = 0; k < N; k++) begin
        if (bus.sel == SW'(k)) begin
          grant_idx = SW'(k);
          granted   = bus.in_valid[k];
        end
      end
    end else begin
      // Search ptr, ptr+1, ... wrapping at N; the first valid channel wins.
      for (int i = 0; i < N; i++) begin
        rr_sum = {1'b0, ptr_q} + (SW+1)'(i);
        if (rr_sum >= (SW+1)'(N))
          rr_sum = rr_sum - (SW+1)'(N);
        rr_idx = rr_sum[SW-1:0];
        if (!granted && bus.in_valid[rr_idx]) begin
          granted   = 1'b1;
          grant_idx = rr_idx;
        end
      end
    end

    for (int k = 0; k < N; k++) begin
      if (grant_idx == SW'(k))
        grant_data = bus.in_data[k*W +: W];
    end
  end

  always_comb begin
    bus.in_ready = '0;
    if (load && granted)
      bus.in_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    ptr_d       = ptr_q;
`ifdef CH_ID_OUT_EN
    out_ch_d    = out_ch_q;
`endif
    if (load) begin
      // Without a grant the register empties but keeps its last data.
      out_valid_d = granted;
      if (granted) begin
        out_data_d = grant_data;
`ifdef CH_ID_OUT_EN
        out_ch_d   = grant_idx;
`endif
        // Only round-robin transfers advance the pointer.
        if (bus.mode)
          ptr_d = (grant_idx == SW'(N-1)) ? '0 : grant_idx + SW'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ptr_q       <= '0;
`ifdef CH_ID_OUT_EN
      out_ch_q    <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ptr_q       <= ptr_d;
`ifdef CH_ID_OUT_EN
      out_ch_q    <= out_ch_d;
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
`ifdef CH_ID_OUT_EN
  assign bus.out_ch    = out_ch_q;
`endif
endmodule
